// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the icache/dcache to RAM arbiter: RAM handshake states,
// arbiter FSM states and the block layout constants.
package cache_mem_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_IGNT  = 2'd1,
    ARB_DGNT  = 2'd2,
    ARB_RETRY = 2'd3
  } arb_state_t;

  // A dcache block is two words; this address bit selects the word.
  localparam int BLOCK_OFS_BIT = 2;
  localparam int ERR_CNT_W     = 8;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of the icache, dcache and RAM port signals seen by the arbiter.
interface cache_mem_arbiter_if;
  import cache_mem_arbiter_pkg::*;

  logic      iren;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;

  logic      dren;
  logic      dwen;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;

  logic      ram_ren;
  logic      ram_wen;
  word_t     ram_addr;
  word_t     ram_store;
  word_t     ram_load;
  ramstate_t ram_state;

  modport slave (
    input  iren, iaddr, dren, dwen, daddr, dstore, ram_load, ram_state,
    output iwait, iload, dwait, dload, ram_ren, ram_wen, ram_addr, ram_store
  );

  modport master (
    output iren, iaddr, dren, dwen, daddr, dstore, ram_load, ram_state,
    input  iwait, iload, dwait, dload, ram_ren, ram_wen, ram_addr, ram_store
  );

endinterface

// File: rtl/cache_mem_arbiter_starve_ctr.sv
// Saturating count of dcache completions that happened while the icache waited.
module arb_starve_ctr #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int W = $clog2(MAX + 1);
  localparam logic [W-1:0] MAX_VAL = W'(MAX);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != MAX_VAL)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign sat = (count_reg == MAX_VAL);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache and dcache word requests onto one RAM port; dcache has
// priority, two-word dcache blocks are never split, icache cannot starve.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int ERR_RETRY  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  cache_mem_arbiter_if.slave   bus,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int RETRY_W = (ERR_RETRY > 1) ? $clog2(ERR_RETRY) : 1;
  localparam logic [RETRY_W-1:0] RETRY_LOAD = RETRY_W'(ERR_RETRY - 1);

  arb_state_t           state_reg;
  logic                 lock_reg;
  logic                 retry_d_reg;
  logic [RETRY_W-1:0]   retry_reg;
  logic [ERR_CNT_W-1:0] err_cnt_reg;

  logic d_req;
  logic i_own;
  logic d_own;
  logic owner_req;
  logic i_done;
  logic d_done;
  logic starve_sat;

  assign d_req     = bus.dren | bus.dwen;
  assign i_own     = (state_reg == ARB_IGNT);
  assign d_own     = (state_reg == ARB_DGNT);
  assign owner_req = i_own ? bus.iren : d_req;
  assign i_done    = i_own & bus.iren & (bus.ram_state == ACCESS);
  assign d_done    = d_own & d_req & (bus.ram_state == ACCESS);

  arb_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (d_done & bus.iren),
    .clr (i_done | ~bus.iren),
    .sat (starve_sat)
  );

  // RAM port follows the current owner; a dcache write masks its read.
  always_comb begin
    bus.ram_ren   = 1'b0;
    bus.ram_wen   = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_store = '0;
    if (i_own) begin
      bus.ram_ren  = bus.iren;
      bus.ram_addr = bus.iaddr;
    end else if (d_own) begin
      bus.ram_wen   = bus.dwen;
      bus.ram_ren   = bus.dren & ~bus.dwen;
      bus.ram_addr  = bus.daddr;
      bus.ram_store = bus.dstore;
    end
  end

  assign bus.iwait = ~i_done;
  assign bus.iload = i_done ? bus.ram_load : '0;
  assign bus.dwait = ~d_done;
  assign bus.dload = d_done ? bus.ram_load : '0;
  assign err_cnt   = err_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ARB_IDLE;
      lock_reg    <= 1'b0;
      retry_d_reg <= 1'b0;
      retry_reg   <= '0;
      err_cnt_reg <= '0;
    end else begin
      unique case (state_reg)
        ARB_IDLE: begin
          if (!d_req) begin
            lock_reg <= 1'b0;
          end
          // An open block keeps the dcache ahead of a starving icache.
          if (d_req && (lock_reg || !(starve_sat && bus.iren))) begin
            state_reg <= ARB_DGNT;
          end else if (bus.iren) begin
            state_reg <= ARB_IGNT;
          end
        end

        ARB_IGNT, ARB_DGNT: begin
          if (!owner_req) begin
            state_reg <= ARB_IDLE;
          end else if (bus.ram_state == ACCESS) begin
            state_reg <= ARB_IDLE;
            if (d_own) begin
              lock_reg <= ~bus.daddr[BLOCK_OFS_BIT];
            end
          end else if (bus.ram_state == ERROR) begin
            if (err_cnt_reg != {ERR_CNT_W{1'b1}}) begin
              err_cnt_reg <= err_cnt_reg + 1'b1;
            end
            retry_d_reg <= d_own;
            retry_reg   <= RETRY_LOAD;
            state_reg   <= ARB_RETRY;
          end
        end

        ARB_RETRY: begin
          if (retry_reg == '0) begin
            state_reg <= retry_d_reg ? ARB_DGNT : ARB_IGNT;
          end else begin
            retry_reg <= retry_reg - 1'b1;
          end
        end

        default: state_reg <= ARB_IDLE;
      endcase
    end
  end

endmodule
